// File: rtl/ahb_tohost_monitor_if.sv
// ahb_tohost_monitor_if: AHB-Lite data-master signals observed by the tohost monitor
interface ahb_tohost_monitor_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  modport master (output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HREADY, HREADYOUT);
  modport slave (input HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HREADY, HREADYOUT);
endinterface

// File: rtl/ahb_tohost_monitor.sv
// ahb_tohost_monitor: watches word writes to tohost and latches pass/fail; run-cycle timeout under TOHOST_TIMEOUT_EN
module ahb_tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd400000
) (
  input  logic                 CLK,
  input  logic                 RES_N,
  ahb_tohost_monitor_if.slave  bus,
  output logic                 DONE,
  output logic                 PASS,
  output logic                 FAIL,
  output logic [30:0]          FAIL_CODE,
  output logic                 TIMEOUT,
  output logic [7:0]           WR_COUNT
);
  typedef enum logic [1:0] {RUN, DPHASE, END, TMO} state_t;
  state_t state, state_nx;
  logic hit, accept, addr_hit, running, sample, term, expire;
  assign accept   = bus.HREADY & bus.HREADYOUT;
  assign addr_hit = bus.HSEL & bus.HTRANS[1] & bus.HWRITE & (bus.HSIZE == 3'b010) & (bus.HADDR == TOHOST_ADDR);
  assign running  = (state == RUN) | (state == DPHASE);
  assign sample   = (state == DPHASE) & hit & accept;
  assign term     = sample & bus.HWDATA[0];
  assign DONE     = state == END;
`ifdef TOHOST_TIMEOUT_EN
  logic [31:0] run_cnt;
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) run_cnt <= '0;
    else if (running) run_cnt <= run_cnt + 32'd1;
  assign expire  = running & (run_cnt == TIMEOUT_CYC - 32'd1);
  assign TIMEOUT = state == TMO;
`else
  assign expire  = 1'b0;
  assign TIMEOUT = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) state <= RUN;
    else state <= state_nx;
  // a terminating sample outranks a timeout landing on the same edge
  always_comb begin
    state_nx = state;
    if (term) state_nx = END;
    else if (expire) state_nx = TMO;
    else if (sample) state_nx = addr_hit ? DPHASE : RUN;
    else if (state == RUN && accept && addr_hit) state_nx = DPHASE;
  end
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) begin
      hit       <= 1'b0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_CODE <= '0;
      WR_COUNT  <= '0;
    end else begin
      if (accept && running) hit <= addr_hit;
      if (term) begin
        PASS      <= bus.HWDATA == 32'h1;
        FAIL      <= bus.HWDATA != 32'h1;
        FAIL_CODE <= bus.HWDATA[31:1];
      end else if (sample && WR_COUNT != 8'hFF) WR_COUNT <= WR_COUNT + 8'd1;
    end
endmodule

// File: tb/tb_ahb_tohost_monitor.sv
// tb_ahb_tohost_monitor: directed checks of the tohost monitor; timeout cases run when TOHOST_TIMEOUT_EN is defined
module tb_ahb_tohost_monitor;
  localparam logic [31:0] A = 32'h0000_1000;
  logic tb_clk = 1'b0;
  logic rst_n = 1'b0;
  logic done, pass, fail, timeout;
  logic [30:0] fail_code;
  logic [7:0] wr_count;
  int n_chk = 0;
  int n_fail = 0;
  ahb_tohost_monitor_if bus ();
  ahb_tohost_monitor #(.TOHOST_ADDR(A), .TIMEOUT_CYC(32'd100)) dut (
    .CLK(tb_clk), .RES_N(rst_n), .bus(bus.slave), .DONE(done), .PASS(pass), .FAIL(fail),
    .FAIL_CODE(fail_code), .TIMEOUT(timeout), .WR_COUNT(wr_count)
  );
  always #5 tb_clk = ~tb_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask
  task automatic idle_addr;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'b000; bus.HADDR = '0;
  endtask
  task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HSIZE = sz; bus.HADDR = a;
  endtask
  task automatic ready(input logic r);
    bus.HREADY = r; bus.HREADYOUT = r;
  endtask
  task automatic reset;
    rst_n = 1'b0;
    idle_addr; ready(1'b1); bus.HWDATA = '0;
    step;
    rst_n = 1'b1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_code"}, fail_code, 0);
    check({tag, "_tmo"}, timeout, 0);
    check({tag, "_cnt"}, wr_count, 0);
  endtask
  // write with wait states; a passing value sits on HWDATA during waits so sampling it shows up
  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input int waits);
    addr_phase(a, sz);
    step;
    idle_addr;
    ready(1'b0);
    bus.HWDATA = 32'h1;
    for (int i = 0; i < waits; i++) begin
      step;
      check("wait_done", done, 0);
    end
    ready(1'b1);
    bus.HWDATA = d;
    step;
  endtask
  initial begin
    idle_addr; ready(1'b1); bus.HWDATA = '0;
    step;
    check_zero("rst");
    rst_n = 1'b1;
    addr_phase(A, 3'b010);
    step;
    check("p1_pre_done", done, 0);
    idle_addr; bus.HWDATA = 32'h1;
    step;
    check("p1_done", done, 1);
    check("p1_pass", pass, 1);
    check("p1_fail", fail, 0);
    check("p1_cnt", wr_count, 0);
    reset;
    wr(A, 3'b010, 32'h0000_000B, 2);
    check("w2_done", done, 1);
    check("w2_pass", pass, 0);
    check("w2_fail", fail, 1);
    check("w2_code", fail_code, 5);
    reset;
    addr_phase(A, 3'b010);
    step;
    bus.HWDATA = 32'h2;
    step;
    bus.HWDATA = 32'h4;
    step;
    idle_addr; bus.HWDATA = 32'h1;
    step;
    check("b2b_cnt", wr_count, 2);
    check("b2b_pass", pass, 1);
    check("b2b_done", done, 1);
    wr(A, 3'b010, 32'h3, 0);
    check("post_pass", pass, 1);
    check("post_fail", fail, 0);
    check("post_code", fail_code, 0);
    check("post_cnt", wr_count, 2);
    reset;
    wr(A, 3'b000, 32'h1, 0);
    check("byte_done", done, 0);
    wr(A + 32'd4, 3'b010, 32'h1, 0);
    check("fromhost_done", done, 0);
    addr_phase(A, 3'b010);
    ready(1'b0);
    step;
    idle_addr; ready(1'b1); bus.HWDATA = 32'h1;
    step;
    check("stalled_addr_done", done, 0);
    addr_phase(A, 3'b010); bus.HWRITE = 1'b0;
    step;
    idle_addr; bus.HWDATA = 32'h1;
    step;
    check("read_done", done, 0);
    wr(A, 3'b010, 32'h2, 0);
    check("ignored_cnt", wr_count, 1);
    check("ignored_done", done, 0);
    reset;
    addr_phase(A, 3'b010);
    step;
    idle_addr; bus.HWDATA = 32'h1;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    step;
    rst_n = 1'b1;
    step;
    step;
    check_zero("after_rst");
`ifdef TOHOST_TIMEOUT_EN
    reset;
    repeat (99) step;
    check("tmo_99", timeout, 0);
    step;
    check("tmo_100", timeout, 1);
    wr(A, 3'b010, 32'h1, 0);
    check("tmo_done", done, 0);
    check("tmo_hold", timeout, 1);
    reset;
    repeat (98) step;
    addr_phase(A, 3'b010);
    step;
    idle_addr; bus.HWDATA = 32'h1;
    step;
    check("race_done", done, 1);
    check("race_tmo", timeout, 0);
`else
    reset;
    addr_phase(A, 3'b010);
    step;
    bus.HWDATA = 32'h0;
    repeat (260) step;
    check("sat_cnt", wr_count, 8'hFF);
    check("no_tmo", timeout, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
